// File: rtl/if_stage_prefetch_if.sv
// Fetch-stage bus: decode-side controls, instruction-memory port and the presented instruction.
// master = the fetch stage, slave = its environment (memory + decode).
interface if_stage_prefetch_if #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int JW = 26
);
   logic          Branch;
   logic          Jump;
   logic          Stall;
   logic [AW-1:0] BranchOffset;
   logic [JW-1:0] JumpAddress;
   logic          ImemReq;
   logic [AW-1:0] ImemAddr;
   logic [DW-1:0] ImemData;
   logic [DW-1:0] Inst;
   logic [AW-1:0] InstPc;
   logic          InstValid;

   modport master (
      input  Branch, Jump, Stall, BranchOffset, JumpAddress, ImemData,
      output ImemReq, ImemAddr, Inst, InstPc, InstValid
   );

   modport slave (
      output Branch, Jump, Stall, BranchOffset, JumpAddress, ImemData,
      input  ImemReq, ImemAddr, Inst, InstPc, InstValid
   );
endinterface

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue, branch/jump redirect and stall backpressure.
// Optional feature macro: IF_PERF_CNT_EN adds FetchCount/FlushCount performance counters.
module if_stage_prefetch #(
   parameter int            AW       = 32,
   parameter int            DW       = 32,
   parameter int            JW       = 26,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic                 Clk,
   input  logic                 Reset,
   if_stage_prefetch_if.master  bus
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]          FetchCount,
   output logic [31:0]          FlushCount
`endif
);

   localparam int            PW   = $clog2(DEPTH);
   localparam int            CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_req_pc;
   logic          r_inflight;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [AW-1:0] r_q_pc   [DEPTH];
   logic [DW-1:0] r_q_data [DEPTH];

   logic          w_valid;
   logic          w_redirect;
   logic          w_req;
   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_credit;
   logic [AW-1:0] w_head_pc;
   logic [DW-1:0] w_head_data;
   logic [AW-1:0] w_seq_pc;
   logic [AW-1:0] w_target;

   assign w_valid     = (r_count != '0);
   assign w_head_pc   = r_q_pc[r_head];
   assign w_head_data = r_q_data[r_head];
   assign w_seq_pc    = w_head_pc + AW'(1);
   assign w_redirect  = (bus.Branch || bus.Jump) && w_valid;

   // Credit covers queued entries plus the response still in flight, so a push can never overflow.
   assign w_credit = r_count + CW'(r_inflight);
   assign w_req    = !Reset && !w_redirect && (w_credit < FULL);
   assign w_push   = r_inflight && !w_redirect && !Reset;
   assign w_pop    = w_valid && !bus.Stall && !w_redirect;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_target = w_seq_pc + bus.BranchOffset;
      if (bus.Jump) begin
         w_target = {w_seq_pc[AW-1:JW], bus.JumpAddress};
      end
   end

   assign bus.ImemReq   = w_req;
   assign bus.ImemAddr  = r_pc;
   assign bus.Inst      = w_valid ? w_head_data : '0;
   assign bus.InstPc    = w_valid ? w_head_pc   : '0;
   assign bus.InstValid = w_valid;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_pc       <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_req;
         if (w_req) begin
            r_pc     <= r_pc + AW'(1);
            r_req_pc <= r_pc;
         end
         if (w_redirect) begin
            r_pc    <= w_target;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // NOTE: queue storage is not reset; the head/tail/count registers alone decide which entries are live.
   always_ff @(posedge Clk) begin
      if (w_push && !w_redirect) begin
         r_q_pc[r_tail]   <= r_req_pc;
         r_q_data[r_tail] <= bus.ImemData;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_fetch_count;
   logic [31:0] r_flush_count;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_fetch_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_pop)      r_fetch_count <= r_fetch_count + 32'd1;
         if (w_redirect) r_flush_count <= r_flush_count + 32'd1;
      end
   end

   assign FetchCount = r_fetch_count;
   assign FlushCount = r_flush_count;
`endif

endmodule

// File: tb/tb_if_stage_prefetch.sv
// Scoreboard bench for if_stage_prefetch: a sequential-stream model predicts every presented instruction.
// Define IF_PERF_CNT_EN to also check the performance counters.
module tb_if_stage_prefetch;

   localparam int          AW       = 32;
   localparam int          DW       = 32;
   localparam int          JW       = 26;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic Clk;
   logic Reset;
   if_stage_prefetch_if #(.AW(AW), .DW(DW), .JW(JW)) bus ();

`ifdef IF_PERF_CNT_EN
   logic [31:0] FetchCount;
   logic [31:0] FlushCount;
`endif

   if_stage_prefetch #(
      .AW(AW), .DW(DW), .JW(JW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
`ifdef IF_PERF_CNT_EN
      ,
      .FetchCount (FetchCount),
      .FlushCount (FlushCount)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;

   exp_t        exp_q[$];
   logic [31:0] gen_pc;
   int          m_pops;
   int          m_flush;
   int          total_pops = 0;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return a + 32'h100;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      else             n_pass++;
   endtask

   // Instruction memory: one-cycle synchronous read.
   always @(posedge Clk) bus.ImemData <= bus.ImemReq ? mem_val(bus.ImemAddr) : 32'hDEAD_BEEF;

   // Monitor: the presented instruction must always be the next one of the current sequential stream.
   always @(negedge Clk) begin
      logic [31:0] pc1;
      logic [31:0] target;
      if (Reset) begin
         exp_q.delete();
         gen_pc  = RESET_PC;
         m_pops  = 0;
         m_flush = 0;
      end else if (bus.InstValid) begin
         check("inst",    {32'h0, bus.Inst},   {32'h0, exp_q[0].inst});
         check("inst_pc", {32'h0, bus.InstPc}, {32'h0, exp_q[0].pc});
         if (bus.Jump || bus.Branch) begin
            pc1 = exp_q[0].pc + 32'd1;
            if (bus.Jump) target = ((pc1 / (32'd1 << JW)) * (32'd1 << JW)) + 32'(bus.JumpAddress);
            else          target = pc1 + bus.BranchOffset;
            exp_q.delete();
            gen_pc = target;
            m_flush++;
         end else if (!bus.Stall) begin
            void'(exp_q.pop_front());
            m_pops++;
            total_pops++;
         end
      end else begin
         check("bubble", {bus.Inst, bus.InstPc}, 64'h0);
      end
      while (exp_q.size() < 8) begin
         exp_q.push_back('{pc: gen_pc, inst: mem_val(gen_pc)});
         gen_pc = gen_pc + 32'd1;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic samp();
      @(negedge Clk);
   endtask

   task automatic idle_inputs();
      bus.Branch       = 1'b0;
      bus.Jump         = 1'b0;
      bus.Stall        = 1'b0;
      bus.BranchOffset = '0;
      bus.JumpAddress  = '0;
   endtask

   // Returns in the cycle whose head is the wanted PC (inputs may then be driven for that cycle).
   task automatic wait_head(input logic [31:0] pc, input string name);
      bit found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
         tick();
         if (bus.InstValid && exp_q[0].pc == pc) found = 1;
      end
      if (!found) check(name, 64'd0, 64'd1);
   endtask

`ifdef IF_PERF_CNT_EN
   task automatic check_perf(input string name);
      check({name, "_fetch"}, {32'h0, FetchCount}, 64'(m_pops));
      check({name, "_flush"}, {32'h0, FlushCount}, 64'(m_flush));
   endtask
`endif

   initial begin
      logic [31:0] held_inst;
      int          valid_cycles;

      Reset = 1'b1;
      idle_inputs();
      repeat (3) tick();
      samp();
      check("rst_imemreq",   {63'h0, bus.ImemReq},   64'h0);
      check("rst_instvalid", {63'h0, bus.InstValid}, 64'h0);
      check("rst_inst",      {32'h0, bus.Inst},      64'h0);
      check("rst_instpc",    {32'h0, bus.InstPc},    64'h0);

      // Reset release, first fetch latency, then one instruction per cycle.
      tick(); Reset = 1'b0;
      samp();
      check("first_req",   {63'h0, bus.ImemReq},   64'h1);
      check("first_addr",  {32'h0, bus.ImemAddr},  64'(RESET_PC));
      check("first_bub0",  {63'h0, bus.InstValid}, 64'h0);
      tick(); samp();
      check("first_bub1",  {63'h0, bus.InstValid}, 64'h0);
      tick(); samp();
      check("first_valid", {63'h0, bus.InstValid}, 64'h1);
      valid_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         tick(); samp();
         if (bus.InstValid) valid_cycles++;
      end
      check("stream_rate", 64'(valid_cycles), 64'd10);

      // Stall: head frozen, fetch stops once the queue and in-flight slot are full.
      tick(); bus.Stall = 1'b1;
      samp();
      held_inst = bus.Inst;
      for (int i = 1; i < 8; i++) begin
         tick(); samp();
         check("stall_hold", {32'h0, bus.Inst}, {32'h0, held_inst});
         if (i >= 4) check("stall_noreq", {63'h0, bus.ImemReq}, 64'h0);
      end
      tick(); bus.Stall = 1'b0;
      valid_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         samp();
         if (bus.InstValid) valid_cycles++;
         tick();
      end
      check("resume_rate", 64'(valid_cycles), 64'd8);

      // Reset with a response in flight.
      samp();
      check("pre_rst_req", {63'h0, bus.ImemReq}, 64'h1);
      tick(); Reset = 1'b1;
      samp();
      check("mid_rst_noreq", {63'h0, bus.ImemReq}, 64'h0);
      tick(); Reset = 1'b0;
      samp();
      check("mid_rst_bub0", {63'h0, bus.InstValid}, 64'h0);
      check("mid_rst_addr", {32'h0, bus.ImemAddr},  64'(RESET_PC));
      tick(); samp();
      check("mid_rst_bub1", {63'h0, bus.InstValid}, 64'h0);

      // Branch back from PC 5 with offset -3.
      wait_head(32'd5, "reach_pc5");
      bus.Branch       = 1'b1;
      bus.BranchOffset = -32'sd3;
      tick();
      bus.Branch = 1'b0;
      samp();
      check("br_req",  {63'h0, bus.ImemReq},   64'h1);
      check("br_addr", {32'h0, bus.ImemAddr},  64'd3);
      check("br_bub0", {63'h0, bus.InstValid}, 64'h0);
      tick(); samp();
      check("br_bub1", {63'h0, bus.InstValid}, 64'h0);
      tick(); samp();
      check("br_valid", {63'h0, bus.InstValid}, 64'h1);
`ifdef IF_PERF_CNT_EN
      tick();
      check("perf_flush_one", {32'h0, FlushCount}, 64'd1);
      check_perf("perf_t3");
`endif

      // Reach 0x0FFFFFFF by branch, then Jump and Branch together: Jump wins.
      wait_head(exp_q[0].pc + 32'd1, "pre_far");
      bus.Branch       = 1'b1;
      bus.BranchOffset = 32'h0FFF_FFFF - (exp_q[0].pc + 32'd1);
      tick();
      bus.Branch = 1'b0;
      wait_head(32'h0FFF_FFFF, "reach_far");
      bus.Jump         = 1'b1;
      bus.Branch       = 1'b1;
      bus.JumpAddress  = 26'h10;
      bus.BranchOffset = $urandom_range(1, 1000);
      tick();
      // Branch while nothing is valid must be ignored.
      bus.Jump         = 1'b0;
      bus.Branch       = 1'b1;
      bus.BranchOffset = 32'd7;
      samp();
      check("jmp_addr",     {32'h0, bus.ImemAddr},  64'h1000_0010);
      check("ign_br_req",   {63'h0, bus.ImemReq},   64'h1);
      check("jmp_bub0",     {63'h0, bus.InstValid}, 64'h0);
      tick();
      bus.Branch = 1'b0;
      samp();
      check("ign_br_addr",  {32'h0, bus.ImemAddr},  64'h1000_0011);
      tick(); samp();
      check("jmp_valid",    {63'h0, bus.InstValid}, 64'h1);
      check("jmp_head_pc",  {32'h0, bus.InstPc},    64'h1000_0010);

      // Randomized traffic against the stream model.
      for (int i = 0; i < 3000; i++) begin
         tick();
         Reset            = ($urandom_range(0, 399) == 0);
         bus.Stall        = ($urandom_range(0, 9) < 3);
         bus.Branch       = ($urandom_range(0, 99) < 5);
         bus.Jump         = ($urandom_range(0, 99) < 3);
         bus.BranchOffset = 32'($urandom_range(0, 40)) - 32'd20;
         bus.JumpAddress  = 26'($urandom_range(0, 200));
      end
      tick();
      Reset = 1'b0;
      idle_inputs();
      repeat (6) tick();
`ifdef IF_PERF_CNT_EN
      check_perf("perf_end");
`endif
      check("enough_pops", 64'(total_pops > 500), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
